// File: rtl/dmem_pkg.sv
// Shared types and helpers for the burst data memory: FSM state encoding,
// default geometry and the byte-strobe merge used on every write.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_e;

    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_DEPTH  = 256;

    function automatic logic [DMEM_DATA_W-1:0] byte_merge(
        input logic [DMEM_DATA_W-1:0]   old_d,
        input logic [DMEM_DATA_W-1:0]   new_d,
        input logic [DMEM_DATA_W/8-1:0] strb
    );
        logic [DMEM_DATA_W-1:0] res;
        res = old_d;
        for (int i = 0; i < DMEM_DATA_W / 8; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_d[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_burst_ctrl_if.sv
// Request / write-beat / read-beat bundle between a load-store unit (master)
// and the burst data memory controller (slave).
interface dmem_burst_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    logic                wdata_valid;
    logic                wdata_ready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;

    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_last;

    logic wr_done;
    logic resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_len,
        output wdata_valid, wdata, wstrb, rdata_ready,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last,
        input  wr_done, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len,
        input  wdata_valid, wdata, wstrb, rdata_ready,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last,
        output wr_done, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with byte write enables and a one-cycle
// registered read port; the read register holds whenever en is low.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto RAM macros; contents survive rst.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= byte_merge(mem[addr], wdata, wstrb);
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_burst_ctrl.sv
// Burst request/response controller in front of dmem_array. Define
// DMEM_RANGE_CHECK_EN to reject bursts running past DEPTH (resp_err) instead of wrapping.
module dmem_burst_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int MAX_BURST = 4,
    parameter int LEN_W     = $clog2(MAX_BURST)
) (
    input logic              clk,
    input logic              rst,
    dmem_burst_ctrl_if.slave bus
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  beat_q;
    logic              issue_done_q;
    logic              pend_q;
    logic [LEN_W-1:0]  out_cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_valid_q, rdata_last_q;
    logic              wr_done_q, resp_err_q;

    logic              req_ready, wdata_ready;
    logic              accept, wr_fire, wr_last, rd_fire, load, issue;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    assign accept  = bus.req_valid && req_ready;
    assign wr_fire = wdata_ready && bus.wdata_valid;
    assign wr_last = wr_fire && (beat_q == len_q);
    assign rd_fire = rdata_valid_q && bus.rdata_ready;
    // Array output acts as a pipeline stage: it drains into rdata_q when the
    // output is empty or being taken, and a new read is issued only into free space.
    assign load    = pend_q && (!rdata_valid_q || bus.rdata_ready);
    assign issue   = (state_q == READ) && !issue_done_q && (!pend_q || load);

    assign mem_en   = (wr_fire || issue) && !err_q;
    assign mem_addr = addr_q + ADDR_W'(beat_q);

`ifdef DMEM_RANGE_CHECK_EN
    assign err_d = ({1'b0, bus.req_addr} + (ADDR_W + 1)'(bus.req_len)) >= (ADDR_W + 1)'(DEPTH);
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (bus.req_valid && !rst) state_d = bus.req_we ? WRITE : READ;
            end
            WRITE: begin
                wdata_ready = 1'b1;
                if (bus.wdata_valid && (beat_q == len_q)) state_d = IDLE;
            end
            READ: begin
                if (rd_fire && rdata_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q        <= '0;
            len_q         <= '0;
            err_q         <= 1'b0;
            beat_q        <= '0;
            issue_done_q  <= 1'b0;
            pend_q        <= 1'b0;
            out_cnt_q     <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            wr_done_q     <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            wr_done_q <= wr_last;

            if (accept) begin
                addr_q       <= bus.req_addr;
                len_q        <= bus.req_len;
                err_q        <= err_d;
                beat_q       <= '0;
                issue_done_q <= 1'b0;
                out_cnt_q    <= '0;
            end else if (wr_fire || issue) begin
                if (beat_q == len_q) issue_done_q <= 1'b1;
                else                 beat_q       <= beat_q + 1'b1;
            end

            if (issue)     pend_q <= 1'b1;
            else if (load) pend_q <= 1'b0;

            if (load) begin
                rdata_q       <= err_q ? '0 : mem_rdata;
                rdata_valid_q <= 1'b1;
                rdata_last_q  <= (out_cnt_q == len_q);
                out_cnt_q     <= out_cnt_q + 1'b1;
            end else if (rd_fire) begin
                rdata_valid_q <= 1'b0;
                rdata_last_q  <= 1'b0;
            end

            if (wr_last)                 resp_err_q <= err_q;
            else if (load)               resp_err_q <= err_q && (out_cnt_q == len_q);
            else if (rd_fire || wr_done_q) resp_err_q <= 1'b0;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (wr_fire),
        .addr  (mem_addr),
        .wdata (bus.wdata),
        .wstrb (bus.wstrb),
        .rdata (mem_rdata)
    );

    assign bus.req_ready   = req_ready;
    assign bus.wdata_ready = wdata_ready;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_last  = rdata_last_q;
    assign bus.wr_done     = wr_done_q;
    assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_dmem_burst_ctrl.sv
// Self-checking bench for dmem_burst_ctrl: directed scenarios plus random bursts
// against a word-array reference model; honours DMEM_RANGE_CHECK_EN.
module tb_dmem_burst_ctrl;

    logic clk;
    logic rst;

    dmem_burst_ctrl_if #(.DATA_W(64), .ADDR_W(8), .LEN_W(2)) bus ();

    dmem_burst_ctrl #(
        .DATA_W    (64),
        .DEPTH     (256),
        .ADDR_W    (8),
        .MAX_BURST (4),
        .LEN_W     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] ref_mem [256];
    logic [63:0] w_data [4];
    logic [7:0]  w_strb [4];
    logic [63:0] last_rdata;
    bit          b2b_arm, b2b_expect;
    logic [7:0]  b2b_addr;
    logic [1:0]  b2b_len;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit range_err(input logic [7:0] a, input logic [1:0] l);
`ifdef DMEM_RANGE_CHECK_EN
        return (int'(a) + int'(l)) >= 256;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++)
            if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    task automatic wait_req_ready(input string tag, output int waits);
        waits = 0;
        while (!bus.req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check(tag, 64'(waits < 50), 64'd1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [1:0] l, input bit gaps);
        int  waits, beat, cyc;
        bit  fire, err;
        err = range_err(a, l);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        wait_req_ready("wr_req_wait", waits);
        @(negedge clk);
        bus.req_valid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= int'(l) && cyc < 100) begin
            check("wr_ready", 64'(bus.wdata_ready), 64'd1);
            check("wr_done_early", 64'(bus.wr_done), 64'd0);
            bus.wdata_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wdata       = w_data[beat];
            bus.wstrb       = w_strb[beat];
            fire            = bus.wdata_valid;
            @(negedge clk);
            cyc++;
            if (fire) begin
                if (!err) model_write(a + 8'(beat), w_data[beat], w_strb[beat]);
                beat++;
            end
        end
        bus.wdata_valid = 1'b0;
        check("wr_beats", 64'(beat), 64'(int'(l) + 1));
        check("wr_done", 64'(bus.wr_done), 64'd1);
        check("wr_resp_err", 64'(bus.resp_err), 64'(err));
        check("wr_idle_ready", 64'(bus.req_ready), 64'd1);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for 3 cycles on beat 1
    task automatic do_read(input logic [7:0] a, input logic [1:0] l, input int mode);
        logic [63:0] exp_q[$];
        bit  err, rdy, hs;
        int  waits, got, cyc, stall, held, first_cyc;
        err = range_err(a, l);
        for (int i = 0; i <= int'(l); i++)
            exp_q.push_back(err ? 64'd0 : ref_mem[a + 8'(i)]);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        bus.req_len   = l;
        wait_req_ready("rd_req_wait", waits);
        if (b2b_expect) begin
            check("b2b_accept_next_cycle", 64'(waits), 64'd0);
            b2b_expect = 1'b0;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rd_busy_ready", 64'(bus.req_ready), 64'd0);
        got = 0; cyc = 0; stall = 0; held = 0; first_cyc = -1;
        while (got <= int'(l) && cyc < 100) begin
            if (bus.rdata_valid && first_cyc < 0) first_cyc = cyc;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 2) != 0);
                default: rdy = !(got == 1 && stall < 3);
            endcase
            if (mode == 2 && got == 1 && !rdy) stall++;
            bus.rdata_ready = rdy;
            hs = bus.rdata_valid && rdy;
            if (bus.rdata_valid) begin
                if (!rdy) held++;
                check("rd_data", bus.rdata, exp_q[got]);
                check("rd_last", 64'(bus.rdata_last), 64'(got == int'(l)));
                if (got == int'(l)) check("rd_resp_err", 64'(bus.resp_err), 64'(err));
            end
            if (hs) last_rdata = bus.rdata;
            if (hs && got == int'(l) && b2b_arm) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b0;
                bus.req_addr  = b2b_addr;
                bus.req_len   = b2b_len;
                check("b2b_no_accept_on_last", 64'(bus.req_ready), 64'd0);
                b2b_arm    = 1'b0;
                b2b_expect = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (hs) got++;
        end
        bus.rdata_ready = 1'b0;
        check("rd_beats", 64'(got), 64'(int'(l) + 1));
        check("rd_first_latency", 64'(first_cyc), 64'd2);
        check("rd_throughput", 64'(cyc), 64'(3 + int'(l) + held));
        check("rd_valid_after_last", 64'(bus.rdata_valid), 64'd0);
        check("rd_idle_ready", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check({tag, "_wdata_ready"}, 64'(bus.wdata_ready), 64'd0);
        check({tag, "_rdata_valid"}, 64'(bus.rdata_valid), 64'd0);
        check({tag, "_rdata_last"}, 64'(bus.rdata_last), 64'd0);
        check({tag, "_wr_done"}, 64'(bus.wr_done), 64'd0);
        check({tag, "_resp_err"}, 64'(bus.resp_err), 64'd0);
        check({tag, "_rdata"}, bus.rdata, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waits;
        logic [7:0] ra;
        logic [1:0] rl;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.wdata_valid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.rdata_ready = 1'b0;
        b2b_arm = 1'b0; b2b_expect = 1'b0; b2b_addr = '0; b2b_len = '0;
        last_rdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 64'(bus.req_ready), 64'd1);

        // Fill the whole array so the model is fully known
        for (int w = 0; w < 64; w++) begin
            for (int i = 0; i < 4; i++) begin
                w_data[i] = {$urandom, $urandom};
                w_strb[i] = 8'hFF;
            end
            do_write(8'(w * 4), 2'd3, 1'b0);
        end

        // Test 1: two-beat write then read back
        w_data[0] = 64'hAAAA_AAAA_AAAA_AAAA; w_strb[0] = 8'hFF;
        w_data[1] = 64'h5555_5555_5555_5555; w_strb[1] = 8'hFF;
        do_write(8'h10, 2'd1, 1'b0);
        do_read(8'h10, 2'd1, 0);
        check("t1_beat1", last_rdata, 64'h5555_5555_5555_5555);

        // Test 2: partial strobe merge
        w_data[0] = 64'h1122_3344_5566_7788; w_strb[0] = 8'hFF;
        do_write(8'h20, 2'd0, 1'b0);
        w_data[0] = 64'h0; w_strb[0] = 8'h0F;
        do_write(8'h20, 2'd0, 1'b1);
        do_read(8'h20, 2'd0, 0);
        check("t2_merge", last_rdata, 64'h1122_3344_0000_0000);

        // Test 3: backpressure on beat 1
        do_read(8'h10, 2'd3, 2);

        // Test 4: write across the top of the array
        w_data[0] = {$urandom, $urandom}; w_strb[0] = 8'hFF;
        w_data[1] = {$urandom, $urandom}; w_strb[1] = 8'hFF;
        do_write(8'hFF, 2'd1, 1'b0);
        do_read(8'hFE, 2'd1, 0);
        do_read(8'h00, 2'd0, 0);
        do_read(8'hFF, 2'd1, 1);

        // Test 6: back-to-back read requests with req_valid held
        b2b_arm = 1'b1; b2b_addr = 8'h10; b2b_len = 2'd2;
        do_read(8'h30, 2'd1, 0);
        do_read(8'h10, 2'd2, 0);

        // Random bursts
        for (int n = 0; n < 60; n++) begin
            ra = 8'($urandom);
            rl = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) begin
                    w_data[i] = {$urandom, $urandom};
                    w_strb[i] = 8'($urandom);
                end
                do_write(ra, rl, 1'b1);
            end else begin
                do_read(ra, rl, 1);
            end
        end

        // Test 5: reset in the middle of a four-beat write
        for (int i = 0; i < 4; i++) begin
            w_data[i] = {$urandom, $urandom};
            w_strb[i] = 8'hFF;
        end
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h40; bus.req_len = 2'd3;
        wait_req_ready("t5_req_wait", waits);
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.wdata_valid = 1'b1;
        bus.wdata       = w_data[0];
        bus.wstrb       = w_strb[0];
        @(negedge clk);
        model_write(8'h40, w_data[0], w_strb[0]);
        bus.wdata_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("t5_in_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_after_release", 64'(bus.req_ready), 64'd1);
        do_read(8'h40, 2'd3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
